switch_reader: RTL and testbench



---
 rtl/switch_reader.sv | 141 ++++++++++++++
 tb/tb_switch_reader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/switch_reader.sv
// switch_reader: memory-mapped input port for 24 DIP switches and a confirm key.
// Raw inputs pass through a 2-flop synchroniser and a stability debouncer.
// A sticky key_pending flag records each debounced key press until the CPU
// reads register 3, which clears it. read_data is zero when not selected,
// so it can be OR-ed onto the shared IO read bus.
module switch_reader #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        SwitchCtrl,
  input  logic        ioRead,
  input  logic [1:0]  switchAddr,
  input  logic [23:0] switches,
  input  logic        confirm_key,
  output logic [15:0] read_data,
  output logic        key_pending
);

  // Count value at which a held candidate is accepted; the counter parks here.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Switch path: synchroniser, shared-group debouncer.
  logic [23:0]      sync1_sw_q,  sync1_sw_d;
  logic [23:0]      sync2_sw_q,  sync2_sw_d;
  logic [23:0]      cand_sw_q,   cand_sw_d;
  logic [CNT_W-1:0] cnt_sw_q,    cnt_sw_d;
  logic [23:0]      stable_sw_q, stable_sw_d;

  // Key path: same structure, one bit wide.
  logic             sync1_key_q,  sync1_key_d;
  logic             sync2_key_q,  sync2_key_d;
  logic             cand_key_q,   cand_key_d;
  logic [CNT_W-1:0] cnt_key_q,    cnt_key_d;
  logic             stable_key_q, stable_key_d;

  // Sticky press flag and its set/clear terms.
  logic key_pending_q, key_pending_d;
  logic key_set;
  logic key_clr;
  logic sel_read;

  assign sel_read = SwitchCtrl && ioRead;

  // Synchronisers: sync2 is the only copy used by the debouncers.
  always_comb begin
    sync1_sw_d  = switches;
    sync2_sw_d  = sync1_sw_q;
    sync1_key_d = confirm_key;
    sync2_key_d = sync1_key_q;
  end

  // Switch debouncer: any bit change restarts the shared count.
  always_comb begin
    cand_sw_d   = cand_sw_q;
    cnt_sw_d    = cnt_sw_q;
    stable_sw_d = stable_sw_q;
    if (sync2_sw_q != cand_sw_q) begin
      cand_sw_d = sync2_sw_q;
      cnt_sw_d  = '0;
    end else if (cnt_sw_q == CNT_LAST) begin
      stable_sw_d = cand_sw_q;
    end else begin
      cnt_sw_d = cnt_sw_q + 1'b1;
    end
  end

  // Key debouncer: identical rule on the single key bit.
  always_comb begin
    cand_key_d   = cand_key_q;
    cnt_key_d    = cnt_key_q;
    stable_key_d = stable_key_q;
    if (sync2_key_q != cand_key_q) begin
      cand_key_d = sync2_key_q;
      cnt_key_d  = '0;
    end else if (cnt_key_q == CNT_LAST) begin
      stable_key_d = cand_key_q;
    end else begin
      cnt_key_d = cnt_key_q + 1'b1;
    end
  end

  // Press flag: set on the edge the debounced key rises; set beats clear so
  // a press coinciding with a status read is never lost.
  always_comb begin
    key_set       = stable_key_d && !stable_key_q;
    key_clr       = sel_read && (switchAddr == 2'b11);
    key_pending_d = key_pending_q;
    if (key_set) begin
      key_pending_d = 1'b1;
    end else if (key_clr) begin
      key_pending_d = 1'b0;
    end
  end

  // All state registers, cleared asynchronously by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_sw_q    <= '0;
      sync2_sw_q    <= '0;
      cand_sw_q     <= '0;
      cnt_sw_q      <= '0;
      stable_sw_q   <= '0;
      sync1_key_q   <= 1'b0;
      sync2_key_q   <= 1'b0;
      cand_key_q    <= 1'b0;
      cnt_key_q     <= '0;
      stable_key_q  <= 1'b0;
      key_pending_q <= 1'b0;
    end else begin
      sync1_sw_q    <= sync1_sw_d;
      sync2_sw_q    <= sync2_sw_d;
      cand_sw_q     <= cand_sw_d;
      cnt_sw_q      <= cnt_sw_d;
      stable_sw_q   <= stable_sw_d;
      sync1_key_q   <= sync1_key_d;
      sync2_key_q   <= sync2_key_d;
      cand_key_q    <= cand_key_d;
      cnt_key_q     <= cnt_key_d;
      stable_key_q  <= stable_key_d;
      key_pending_q <= key_pending_d;
    end
  end

  // Read mux: zero-latency view of registered state; idle value is zero for
  // the wired-OR bus. Register 3 shows the flag before any clear takes effect.
  always_comb begin
    read_data = 16'h0000;
    if (sel_read) begin
      case (switchAddr)
        2'b00, 2'b01: read_data = stable_sw_q[15:0];
        2'b10:        read_data = {8'h00, stable_sw_q[23:16]};
        default:      read_data = {15'h0000, key_pending_q};
      endcase
    end
  end

  assign key_pending = key_pending_q;

endmodule

// File: tb/tb_switch_reader.sv
// Bench for switch_reader with a short debounce window.
module tb_switch_reader;

  localparam int D = 4;

  logic        clock;
  logic        reset;
  logic        SwitchCtrl;
  logic        ioRead;
  logic [1:0]  switchAddr;
  logic [23:0] switches;
  logic        confirm_key;
  logic [15:0] read_data;
  logic        key_pending;

  int total = 0;
  int bad   = 0;

  switch_reader #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .SwitchCtrl (SwitchCtrl),
    .ioRead     (ioRead),
    .switchAddr (switchAddr),
    .switches   (switches),
    .confirm_key(confirm_key),
    .read_data  (read_data),
    .key_pending(key_pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: history of raw samples per edge. A value is accepted
  // once the D+1 samples ending two edges ago are all identical.
  logic [23:0] q_sw[$];
  logic [23:0] q_key[$];
  logic [23:0] m_sw;
  logic        m_key;
  logic        m_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_sw = {};
    q_key = {};
    for (int i = 0; i < D + 3; i++) begin
      q_sw.push_back(24'h0);
      q_key.push_back(24'h0);
    end
    m_sw = 24'h0;
    m_key = 1'b0;
    m_pend = 1'b0;
  endtask

  function automatic logic run_ok(input logic [23:0] q[$]);
    for (int j = 0; j <= D; j++)
      if (q[j] != q[D]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(input logic [23:0] sw, input logic k, input logic clr);
    logic prev;
    q_sw.push_back(sw);
    void'(q_sw.pop_front());
    q_key.push_back({23'h0, k});
    void'(q_key.pop_front());
    if (run_ok(q_sw)) m_sw = q_sw[D];
    prev = m_key;
    if (run_ok(q_key)) m_key = q_key[D][0];
    if (!prev && m_key) m_pend = 1'b1;
    else if (clr) m_pend = 1'b0;
  endtask

  function automatic logic [15:0] exp_read(input logic sc, input logic rd, input logic [1:0] a);
    if (!(sc && rd)) return 16'h0000;
    case (a)
      2'b00, 2'b01: return m_sw[15:0];
      2'b10:        return {8'h00, m_sw[23:16]};
      default:      return {15'h0000, m_pend};
    endcase
  endfunction

  // One clock cycle: drive, check against model mid-cycle, clock, update model.
  task automatic step(input logic [23:0] sw, input logic k, input logic sc,
                      input logic rd, input logic [1:0] a);
    switches = sw;
    confirm_key = k;
    SwitchCtrl = sc;
    ioRead = rd;
    switchAddr = a;
    @(negedge clock);
    chk("model_read_data", {16'h0, read_data}, {16'h0, exp_read(sc, rd, a)});
    chk("model_key_pending", {31'h0, key_pending}, {31'h0, m_pend});
    @(posedge clock);
    model_edge(sw, k, sc && rd && (a == 2'b11));
    #1;
  endtask

  typedef struct {
    logic [23:0] sw;
    logic        sc;
    logic        rd;
    logic [1:0]  addr;
    logic [15:0] exp_rd;
  } vec_t;

  initial begin
    vec_t tbl[12];
    logic [23:0] rsw;
    logic rk;

    // Switches go 0 -> A5C33C; row i is checked after edge i.
    for (int i = 0; i < 12; i++)
      tbl[i] = '{24'hA5C33C, 1'b1, 1'b1, 2'b00, (i >= 7) ? 16'hC33C : 16'h0000};
    tbl[9]  = '{24'hA5C33C, 1'b1, 1'b1, 2'b10, 16'h00A5};
    tbl[10] = '{24'hA5C33C, 1'b0, 1'b1, 2'b00, 16'h0000};
    tbl[11] = '{24'hA5C33C, 1'b1, 1'b1, 2'b01, 16'hC33C};

    reset = 1'b1;
    SwitchCtrl = 1'b0;
    ioRead = 1'b0;
    switchAddr = 2'b00;
    switches = 24'h0;
    confirm_key = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    SwitchCtrl = 1'b1;
    ioRead = 1'b1;
    #1;
    chk("reset_read_data", {16'h0, read_data}, 32'h0);
    chk("reset_key_pending", {31'h0, key_pending}, 32'h0);

    repeat (10) step(24'h0, 1'b0, 1'b1, 1'b1, 2'b00);

    // Latency and read mux table.
    for (int i = 0; i < 12; i++) begin
      switches = tbl[i].sw;
      SwitchCtrl = tbl[i].sc;
      ioRead = tbl[i].rd;
      switchAddr = tbl[i].addr;
      #1;
      chk($sformatf("latency_row%0d", i), {16'h0, read_data}, {16'h0, tbl[i].exp_rd});
      step(tbl[i].sw, 1'b0, tbl[i].sc, tbl[i].rd, tbl[i].addr);
    end

    // Glitch rejection: 3-cycle pulse on bit 0.
    repeat (10) step(24'h0, 1'b0, 1'b1, 1'b1, 2'b00);
    repeat (3) step(24'h000001, 1'b0, 1'b1, 1'b1, 2'b00);
    for (int i = 0; i < 20; i++) begin
      step(24'h0, 1'b0, 1'b1, 1'b1, 2'b00);
      chk("glitch_read_data", {16'h0, read_data}, 32'h0);
    end

    // Bouncing key then held: flag sets on the 7th edge after the final rise.
    step(24'h0, 1'b1, 1'b0, 1'b0, 2'b00);
    step(24'h0, 1'b0, 1'b0, 1'b0, 2'b00);
    step(24'h0, 1'b1, 1'b0, 1'b0, 2'b00);
    step(24'h0, 1'b0, 1'b0, 1'b0, 2'b00);
    chk("bounce_no_set", {31'h0, key_pending}, 32'h0);
    for (int j = 1; j <= 10; j++) begin
      step(24'h0, 1'b1, 1'b0, 1'b0, 2'b00);
      chk($sformatf("bounce_held%0d", j), {31'h0, key_pending}, (j >= 7) ? 32'h1 : 32'h0);
    end

    // Status read returns the pre-clear value, then clears.
    switches = 24'h0; confirm_key = 1'b1; SwitchCtrl = 1'b1; ioRead = 1'b1; switchAddr = 2'b11;
    #1 chk("read11_first", {16'h0, read_data}, 32'h1);
    step(24'h0, 1'b1, 1'b1, 1'b1, 2'b11);
    chk("read11_cleared", {31'h0, key_pending}, 32'h0);
    #1 chk("read11_second", {16'h0, read_data}, 32'h0);
    step(24'h0, 1'b1, 1'b1, 1'b1, 2'b11);
    repeat (10) step(24'h0, 1'b0, 1'b0, 1'b0, 2'b00);
    chk("release_no_set", {31'h0, key_pending}, 32'h0);
    repeat (10) step(24'h0, 1'b1, 1'b0, 1'b0, 2'b00);
    chk("repress_set", {31'h0, key_pending}, 32'h1);
    step(24'h0, 1'b1, 1'b1, 1'b1, 2'b11);
    repeat (10) step(24'h0, 1'b0, 1'b0, 1'b0, 2'b00);
    chk("pre_collision_clear", {31'h0, key_pending}, 32'h0);

    // Collision: clearing read on the same edge the debounced key rises.
    repeat (6) step(24'h0, 1'b1, 1'b0, 1'b0, 2'b00);
    chk("collision_before", {31'h0, key_pending}, 32'h0);
    step(24'h0, 1'b1, 1'b1, 1'b1, 2'b11);
    chk("collision_set_wins", {31'h0, key_pending}, 32'h1);

    // Decode isolation.
    switches = 24'h0; confirm_key = 1'b1; SwitchCtrl = 1'b0; ioRead = 1'b1; switchAddr = 2'b11;
    #1 chk("iso_noctrl_read", {16'h0, read_data}, 32'h0);
    step(24'h0, 1'b1, 1'b0, 1'b1, 2'b11);
    chk("iso_noctrl_pend", {31'h0, key_pending}, 32'h1);
    SwitchCtrl = 1'b1; ioRead = 1'b0;
    #1 chk("iso_noread_read", {16'h0, read_data}, 32'h0);
    step(24'h0, 1'b1, 1'b1, 1'b0, 2'b11);
    chk("iso_noread_pend", {31'h0, key_pending}, 32'h1);

    // Asynchronous reset mid-cycle with everything set.
    repeat (10) step(24'hFFFFFF, 1'b1, 1'b1, 1'b1, 2'b00);
    chk("pre_reset_read", {16'h0, read_data}, 32'hFFFF);
    chk("pre_reset_pend", {31'h0, key_pending}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_read", {16'h0, read_data}, 32'h0);
    chk("async_reset_pend", {31'h0, key_pending}, 32'h0);
    reset = 1'b0;
    model_reset();
    for (int i = 1; i <= 8; i++) begin
      step(24'hFFFFFF, 1'b0, 1'b1, 1'b1, 2'b00);
      chk($sformatf("post_reset_edge%0d", i), {16'h0, read_data}, (i >= 7) ? 32'hFFFF : 32'h0);
    end

    // Random traffic against the model.
    rsw = 24'hFFFFFF;
    rk = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) rsw = 24'($urandom);
      if ($urandom_range(5) == 0) rk = ~rk;
      step(rsw, rk, 1'($urandom_range(1)), 1'($urandom_range(1)), 2'($urandom_range(3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
